// File: rtl/mc_req_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------------------
// mc_req_arbiter: round-robin sharing of one manycore out-request port with per-requester
// credit tracking and owner-tagged response steering.                      Revision 1.0
// ----------------------------------------------------------------------------------------
module mc_req_arbiter #(
  parameter int num_req_p      = 2,
  parameter int packet_width_p = 64,
  parameter int reg_id_width_p = 5,
  parameter int reg_id_lsb_p   = 0,
  parameter int data_width_p   = 32,
  parameter int max_out_p      = 8
) (
  input  logic                                  clk_i,
  input  logic                                  reset_n_i,
  input  logic                                  pause_i,
  input  logic [num_req_p-1:0]                  req_v_i,
  input  logic [num_req_p*packet_width_p-1:0]   req_packet_i,
  output logic [num_req_p-1:0]                  req_ready_o,
  output logic                                  out_v_o,
  output logic [packet_width_p-1:0]             out_packet_o,
  input  logic                                  out_ready_i,
  input  logic                                  returned_v_i,
  input  logic [reg_id_width_p-1:0]             returned_reg_id_i,
  input  logic [data_width_p-1:0]               returned_data_i,
  input  logic                                  returned_credit_v_i,
  input  logic [reg_id_width_p-1:0]             returned_credit_reg_id_i,
  output logic [num_req_p-1:0]                  resp_v_o,
  output logic [data_width_p-1:0]               resp_data_o,
  output logic [reg_id_width_p-1:0]             resp_tag_o,
  output logic                                  resp_is_credit_o,
  output logic                                  idle_o,
  output logic                                  err_o
);

  localparam int OW     = $clog2(num_req_p);
  localparam int CW     = $clog2(max_out_p + 1);
  localparam int RID_HI = reg_id_lsb_p + reg_id_width_p - 1;
  localparam logic [OW:0] NREQ_W = (OW + 1)'(num_req_p);
  localparam logic [reg_id_width_p-1:0] OWNER_MASK =
    {{OW{1'b1}}, {(reg_id_width_p - OW){1'b0}}};

  // Registered state
  logic [OW-1:0]               r_ptr;
  logic                        r_out_v;
  logic [packet_width_p-1:0]   r_out_pkt;
  logic [num_req_p-1:0]        r_resp_v;
  logic [data_width_p-1:0]     r_resp_data;
  logic [reg_id_width_p-1:0]   r_resp_tag;
  logic                        r_resp_cr;
  logic                        r_hold_v;
  logic [num_req_p-1:0]        r_hold_oh;
  logic [reg_id_width_p-1:0]   r_hold_tag;
  logic                        r_err;

  // Combinational signals
  logic                        w_can_issue;
  logic [num_req_p-1:0]        w_elig;
  logic [num_req_p-1:0]        w_grant;
  logic [OW-1:0]               w_grant_idx;
  logic [OW-1:0]               w_cand;
  logic                        w_found;
  logic [OW-1:0]               w_ptr_nxt;
  logic [packet_width_p-1:0]   w_sel_pkt;
  logic [num_req_p-1:0]        w_cnt_zero;
  logic [num_req_p-1:0]        w_uflow;

  logic [OW-1:0]               w_ld_owner;
  logic [OW-1:0]               w_cr_owner;
  logic                        w_ld_legal;
  logic                        w_cr_legal;
  logic                        w_ld_fire;
  logic                        w_cr_fire;
  logic [num_req_p-1:0]        w_ld_oh;
  logic [num_req_p-1:0]        w_cr_oh;
  logic [reg_id_width_p-1:0]   w_ld_tag;
  logic [reg_id_width_p-1:0]   w_cr_tag;
  logic                        w_hold_ovf;

  // A new packet may enter only when the output register is free this cycle
  assign w_can_issue = reset_n_i && !pause_i && (!r_out_v || out_ready_i);

  assign w_ld_owner = returned_reg_id_i[reg_id_width_p-1 -: OW];
  assign w_cr_owner = returned_credit_reg_id_i[reg_id_width_p-1 -: OW];
  assign w_ld_legal = ({1'b0, w_ld_owner} < NREQ_W);
  assign w_cr_legal = ({1'b0, w_cr_owner} < NREQ_W);
  assign w_ld_fire  = returned_v_i && w_ld_legal;
  assign w_cr_fire  = returned_credit_v_i && w_cr_legal;
  assign w_ld_oh    = num_req_p'(1) << w_ld_owner;
  assign w_cr_oh    = num_req_p'(1) << w_cr_owner;
  assign w_ld_tag   = returned_reg_id_i & ~OWNER_MASK;
  assign w_cr_tag   = returned_credit_reg_id_i & ~OWNER_MASK;
  // Only a load+credit pair arriving while the holding slot is still busy cannot be absorbed
  assign w_hold_ovf = w_ld_fire && w_cr_fire && r_hold_v;

  for (genvar gi = 0; gi < num_req_p; gi++) begin : g_req
    logic [CW-1:0] r_cnt;
    logic [CW:0]   w_sum;
    logic [1:0]    w_dec;

    assign w_dec = {1'b0, w_ld_fire && (w_ld_owner == OW'(gi))} +
                   {1'b0, w_cr_fire && (w_cr_owner == OW'(gi))};
    assign w_sum = {1'b0, r_cnt} + {{CW{1'b0}}, w_grant[gi]};
    assign w_uflow[gi]    = ((CW + 1)'(w_dec) > w_sum);
    assign w_cnt_zero[gi] = (r_cnt == '0);
    assign w_elig[gi]     = req_v_i[gi] && (r_cnt < CW'(max_out_p)) && w_can_issue;

    always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
        r_cnt <= '0;
      end else if (w_uflow[gi]) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= CW'(w_sum - (CW + 1)'(w_dec));
      end
    end
  end

  // Round-robin search starting at r_ptr, first eligible requester wins
  always_comb begin
    w_grant     = '0;
    w_grant_idx = '0;
    w_cand      = '0;
    w_found     = 1'b0;
    for (int k = 0; k < num_req_p; k++) begin
      if (!w_found) begin
        if (int'(r_ptr) + k < num_req_p) begin
          w_cand = OW'(int'(r_ptr) + k);
        end else begin
          w_cand = OW'(int'(r_ptr) + k - num_req_p);
        end
        if (w_elig[w_cand]) begin
          w_found     = 1'b1;
          w_grant_idx = w_cand;
        end
      end
    end
    if (w_found) begin
      w_grant[w_grant_idx] = 1'b1;
    end
  end

  assign w_ptr_nxt = (w_grant_idx == OW'(num_req_p - 1)) ? '0 : w_grant_idx + OW'(1);

  always_comb begin
    w_sel_pkt = req_packet_i[int'(w_grant_idx)*packet_width_p +: packet_width_p];
    w_sel_pkt[RID_HI -: OW] = w_grant_idx;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_ptr     <= '0;
      r_out_v   <= 1'b0;
      r_out_pkt <= '0;
    end else if (w_found) begin
      r_out_v   <= 1'b1;
      r_out_pkt <= w_sel_pkt;
      r_ptr     <= w_ptr_nxt;
    end else if (r_out_v && out_ready_i) begin
      r_out_v   <= 1'b0;
    end
  end

  // Load data takes the response slot first; a coincident credit waits one cycle in the hold slot
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_resp_v    <= '0;
      r_resp_data <= '0;
      r_resp_tag  <= '0;
      r_resp_cr   <= 1'b0;
      r_hold_v    <= 1'b0;
      r_hold_oh   <= '0;
      r_hold_tag  <= '0;
    end else if (w_ld_fire) begin
      r_resp_v    <= w_ld_oh;
      r_resp_data <= returned_data_i;
      r_resp_tag  <= w_ld_tag;
      r_resp_cr   <= 1'b0;
      if (w_cr_fire && !r_hold_v) begin
        r_hold_v   <= 1'b1;
        r_hold_oh  <= w_cr_oh;
        r_hold_tag <= w_cr_tag;
      end
    end else if (r_hold_v) begin
      r_resp_v    <= r_hold_oh;
      r_resp_data <= '0;
      r_resp_tag  <= r_hold_tag;
      r_resp_cr   <= 1'b1;
      r_hold_v    <= w_cr_fire;
      r_hold_oh   <= w_cr_oh;
      r_hold_tag  <= w_cr_tag;
    end else if (w_cr_fire) begin
      r_resp_v    <= w_cr_oh;
      r_resp_data <= '0;
      r_resp_tag  <= w_cr_tag;
      r_resp_cr   <= 1'b1;
    end else begin
      r_resp_v    <= '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_err <= 1'b0;
    end else if ((returned_v_i && !w_ld_legal) || (returned_credit_v_i && !w_cr_legal) ||
                 (|w_uflow) || w_hold_ovf) begin
      r_err <= 1'b1;
    end
  end

  assign req_ready_o      = w_grant;
  assign out_v_o          = r_out_v;
  assign out_packet_o     = r_out_pkt;
  assign resp_v_o         = r_resp_v;
  assign resp_data_o      = r_resp_data;
  assign resp_tag_o       = r_resp_tag;
  assign resp_is_credit_o = r_resp_cr;
  assign err_o            = r_err;
  assign idle_o           = !reset_n_i || (!r_out_v && (&w_cnt_zero));

endmodule
`default_nettype wire
